// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RISC control FSM with memory handshake.
// Optional stall timeout is built when MCTRL_TIMEOUT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       ab_ld,
  output logic       aluout_ld,
  output logic       mdr_ld,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] pc_src_sel,
  output logic       alu_src_sel,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       timeout
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  logic r_illegal, w_to;
  logic w_alui, w_ld, w_st, w_beqz, w_jmp, w_jal, w_halt, w_legal;
  assign w_alui  = opcode == 6'd1;
  assign w_ld    = opcode == 6'd2;
  assign w_st    = opcode == 6'd3;
  assign w_beqz  = opcode == 6'd4;
  assign w_jmp   = opcode == 6'd5;
  assign w_jal   = opcode == 6'd6;
  assign w_halt  = opcode == 6'h3f;
  assign w_legal = opcode <= 6'd6;
`ifdef MCTRL_TIMEOUT_EN
  localparam logic        TO_EN = MEM_TIMEOUT != 0;
  localparam logic [15:0] TO_M1 = 16'(MEM_TIMEOUT - 1);
  logic [15:0] r_stall;
  logic        r_timeout, w_stall;
  assign w_stall = (r_state == S_FETCH || r_state == S_MEM) && !mem_ready;
  // abort on the stall cycle that brings the count up to the limit
  assign w_to    = TO_EN && w_stall && r_stall == TO_M1;
  assign timeout = r_timeout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_stall <= (w_next != r_state) ? 16'd0 : w_stall ? r_stall + 16'd1 : r_stall;
      if (w_to) r_timeout <= 1'b1;
    end
`else
  logic w_unused_to;
  assign w_unused_to = ^MEM_TIMEOUT;
  assign w_to        = 1'b0;
  assign timeout     = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && !w_legal && !w_halt) r_illegal <= 1'b1;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_to ? S_HALT : S_FETCH;
      S_DECODE: w_next = (w_halt || !w_legal) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (w_ld || w_st) ? S_MEM : (w_beqz || w_jmp) ? S_FETCH : S_WB;
      S_MEM:    w_next = mem_ready ? (w_ld ? S_WB : S_FETCH) : w_to ? S_HALT : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end
  always_comb begin
    pc_ld       = 1'b0;
    ir_ld       = 1'b0;
    ab_ld       = 1'b0;
    aluout_ld   = 1'b0;
    mdr_ld      = 1'b0;
    reg_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_src_sel  = 2'b00;
    alu_src_sel = 1'b0;
    wb_sel      = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = mem_ready;
        pc_ld  = mem_ready;
      end
      S_DECODE: ab_ld = 1'b1;
      S_EXEC: begin
        aluout_ld   = 1'b1;
        alu_src_sel = w_alui | w_ld | w_st;
        pc_ld       = w_beqz ? zero : (w_jmp | w_jal);
        pc_src_sel  = w_beqz ? 2'b01 : (w_jmp | w_jal) ? 2'b10 : 2'b00;
      end
      S_MEM: begin
        mem_rd = w_ld;
        mem_wr = w_st;
        mdr_ld = w_ld & mem_ready;
      end
      S_WB: begin
        reg_wr = 1'b1;
        wb_sel = w_ld ? 2'b01 : w_jal ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end
  assign halted  = r_state == S_HALT;
  assign illegal = r_illegal;
endmodule
